dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the core's load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake and performs a RISC-V byte, half or word access on internal word-organised storage.
- Returns read data or an error after a fixed, parameterised latency, over a second valid/ready handshake.
- Replaces the zero-latency data memory so the core can be exercised against a realistic multi-cycle memory.

---
 rtl/dmem_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Memory-side end of the core's load/store interface. Accepts one
//            request at a time, performs a RISC-V byte/half/word access on
//            internal word storage and answers after LATENCY cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk, rst          - clock (rising edge), synchronous active-high reset
//            req_valid/ready   - request handshake
//            req_we            - 1 = store, 0 = load
//            req_addr          - byte address
//            req_wdata         - store data, right-aligned
//            req_funct3        - 000 B, 001 H, 010 W, 100 BU, 101 HU
//            rsp_valid/ready   - response handshake
//            rsp_rdata         - load result (0 for stores and errors)
//            rsp_err           - access faulted
//            rd_count, wr_count, err_count - saturating response counters,
//                                present only when DMEM_STATS_EN is defined
// Options  : `define DMEM_STATS_EN to add the statistics counters.
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
`endif
);

    localparam int          C_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] C_DEPTH  = 30'(DEPTH_WORDS);
    localparam logic [3:0]  C_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        commit;      // edge entering RESP
    logic        cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_f3;
    logic        cmd_err;
    logic [C_IDX_W-1:0] cmd_idx;
    logic [31:0] cmd_word, ld_data, st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  st_be;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // With LATENCY==1 the commit happens on the accept edge itself, so the
    // access must be evaluated from the live request rather than the copy.
    assign cmd_we    = (state_q == S_IDLE) ? req_we     : we_q;
    assign cmd_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
    assign cmd_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    assign cmd_f3    = (state_q == S_IDLE) ? req_funct3 : f3_q;
    assign cmd_idx   = cmd_addr[C_IDX_W+1:2];
    assign cmd_word  = mem_q[cmd_idx];

    always_comb begin
        cmd_err = 1'b0;
        case (cmd_f3)
            3'b000:  cmd_err = 1'b0;
            3'b001:  cmd_err = cmd_addr[0];
            3'b010:  cmd_err = |cmd_addr[1:0];
            3'b100:  cmd_err = cmd_we;
            3'b101:  cmd_err = cmd_we | cmd_addr[0];
            default: cmd_err = 1'b1;
        endcase
        if (cmd_addr[31:2] >= C_DEPTH) begin
            cmd_err = 1'b1;
        end
    end

    assign ld_byte = cmd_word[8*cmd_addr[1:0] +: 8];
    assign ld_half = cmd_addr[1] ? cmd_word[31:16] : cmd_word[15:0];

    always_comb begin
        ld_data = cmd_word;
        st_data = cmd_wdata;
        st_be   = 4'b1111;
        case (cmd_f3[1:0])
            2'b00: begin
                ld_data = {{24{ld_byte[7] & ~cmd_f3[2]}}, ld_byte};
                st_data = {4{cmd_wdata[7:0]}};
                st_be   = 4'b0001 << cmd_addr[1:0];
            end
            2'b01: begin
                ld_data = {{16{ld_half[15] & ~cmd_f3[2]}}, ld_half};
                st_data = {2{cmd_wdata[15:0]}};
                st_be   = cmd_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                ld_data = cmd_word;
                st_data = cmd_wdata;
                st_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            if (commit) begin
                err_q   <= cmd_err;
                rdata_q <= (!cmd_we && !cmd_err) ? ld_data : 32'd0;
            end else if (rsp_valid && rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // Storage has no reset; a reset coinciding with the commit edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && cmd_we && !cmd_err) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem_q[cmd_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else if (rsp_valid && rsp_ready) begin
            if (err_q) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else if (we_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder (table of directed
//            accesses plus hand-written stall and reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
`ifdef DMEM_STATS_EN
    logic [15:0] rd_count, wr_count, err_count;
`endif

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
`ifdef DMEM_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [24];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_rd = 0;
    int   exp_wr = 0;
    int   exp_er = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, " valid after hs"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, " ready after hs"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_rsp(input string tag, output int n);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic txn(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_funct3 = v.f3;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(tag, n);
        chk({tag, " latency"}, 32'(n), 32'(LAT));
        chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        handshake(tag);
        if (v.exp_err) exp_er++;
        else if (v.we) exp_wr++;
        else exp_rd++;
    endtask

    task automatic chk_stats(input string tag);
`ifdef DMEM_STATS_EN
        chk({tag, " rd_count"},  {16'd0, rd_count},  32'(exp_rd));
        chk({tag, " wr_count"},  {16'd0, wr_count},  32'(exp_wr));
        chk({tag, " err_count"}, {16'd0, err_count}, 32'(exp_er));
`else
        n_chk = n_chk + 0;
`endif
    endtask

    initial begin
        int n;
        //           we    addr           wdata          f3      exp_rdata      err
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 3'b010, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0011, 32'h0000_0080, 3'b000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0011, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0011, 32'h0,        3'b100, 32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,        3'b001, 32'hFFFF80EF, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0,        3'b010, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0013, 32'h0000_1234, 3'b001, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_1000, 32'h0,        3'b010, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,        3'b011, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0012, 32'h0000_CAFE, 3'b001, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0012, 32'h0,        3'b101, 32'h0000_CAFE, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0012, 32'h0,        3'b001, 32'hFFFF_CAFE, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'hCAFE80EF, 1'b0};
        vecs[16] = '{1'b1, 32'h0000_0010, 32'h0000_0055, 3'b100, 32'h0000_0000, 1'b1};
        vecs[17] = '{1'b0, 32'h0000_0013, 32'h0,        3'b000, 32'hFFFFFFCA, 1'b0};
        vecs[18] = '{1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'hCAFE80EF, 1'b0};
        vecs[19] = '{1'b1, 32'h0000_0FFC, 32'h01020304, 3'b010, 32'h0000_0000, 1'b0};
        vecs[20] = '{1'b0, 32'h0000_0FFC, 32'h0,        3'b010, 32'h01020304, 1'b0};
        vecs[21] = '{1'b0, 32'h0000_0FFF, 32'h0,        3'b100, 32'h0000_0001, 1'b0};
        vecs[22] = '{1'b0, 32'h8000_0010, 32'h0,        3'b010, 32'h0000_0000, 1'b1};
        vecs[23] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 1'b1};

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err",   {31'd0, rsp_err}, 32'd0);
        chk_stats("reset");

        for (int i = 0; i < 24; i++) begin
            txn(vecs[i], $sformatf("vec%0d", i));
        end
        chk_stats("after table");

        // Response stall with a second request waiting behind it.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_addr = 32'hFFC;
        wait_rsp("stall", n);
        chk("stall latency", 32'(n), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            chk("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall rsp_rdata", rsp_rdata, 32'hCAFE80EF);
            chk("stall rsp_err",   {31'd0, rsp_err}, 32'd0);
            chk("stall req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("stall hs rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("stall 2nd not yet accepted", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("stall 2nd accepted", {31'd0, req_ready}, 32'd0);
        wait_rsp("stall2", n);
        chk("stall2 latency", 32'(n), 32'(LAT));
        chk("stall2 rdata", rsp_rdata, 32'h01020304);
        handshake("stall2");
        exp_rd += 2;
        chk_stats("after stall");

        // Reset while a store waits: the store must never land.
        txn('{1'b1, 32'h20, 32'h0BADF00D, 3'b010, 32'h0, 1'b0}, "pre-rst SW");
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        chk("rst in WAIT rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_er = 0;
        chk("post-rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("post-rst rsp_rdata", rsp_rdata, 32'd0);
        chk_stats("post-rst");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk("post-rst no rsp", {31'd0, rsp_valid}, 32'd0);
        end
        txn('{1'b0, 32'h20, 32'h0, 3'b010, 32'h0BADF00D, 1'b0}, "post-rst LW");
        chk_stats("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
